// File: rtl/cic_decim_ctrl_pkg.sv
// Shared types and constants for the CIC decimator sequencing controller.
// Holds the FSM state encoding, default sizing and the warm-up counter width helper.
package cic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } cic_state_e;

  localparam int CIC_STAGES_DEF    = 2;
  localparam int CIC_WIDTH_CTR_DEF = 4;

  // Smallest width w (at least 1) with 2^w > stages, so the warm-up count never wraps.
  function automatic int cic_warm_width(input int stages);
    int w;
    w = 1;
    while ((1 << w) <= stages) w++;
    return w;
  endfunction

endpackage

// File: rtl/cic_decim_counter.sv
// Loadable wrap counter for the CIC decimation period.
// Latches the ratio on load and flags the sample that completes each period.
module cic_decim_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  input  logic             inc,
  output logic             period_end
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] ratio_q, ratio_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign period_end = inc && (cnt_q == ratio_q);

  always_comb begin
    ratio_d = ratio_q;
    cnt_d   = cnt_q;
    if (load) ratio_d = load_val;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      // A ratio of all ones wraps naturally, giving the maximum period of 2^WIDTH.
      cnt_d = period_end ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ratio_q <= '0;
      cnt_q   <= '0;
    end else begin
      ratio_q <= ratio_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencing controller: enables, warm-up suppression and output handshake.
// Define CIC_DROP_CNT_EN to add the saturating drop_cnt port counting overwritten words.
module cic_decim_ctrl
  import cic_pkg::*;
#(
  parameter int STAGES     = CIC_STAGES_DEF,
  parameter int WIDTH_CTR  = CIC_WIDTH_CTR_DEF,
  parameter int WIDTH_WARM = cic_warm_width(CIC_STAGES_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [WIDTH_CTR-1:0] cfg_ratio,
  input  logic                 in_valid,
  input  logic                 out_ready,
  output logic                 integ_en,
  output logic                 integ_clr,
  output logic                 comb_en,
  output logic                 comb_clr,
  output logic                 out_valid,
  output logic                 overrun,
  output logic [1:0]           state
`ifdef CIC_DROP_CNT_EN
  ,
  output logic [3:0]           drop_cnt
`endif
);

  localparam logic [WIDTH_WARM:0] STAGES_W   = (WIDTH_WARM + 1)'(STAGES);
  localparam logic [WIDTH_WARM:0] WARM_ONE_W = (WIDTH_WARM + 1)'(1);

  cic_state_e            state_q, state_d;
  logic [WIDTH_WARM-1:0] warm_q, warm_d;
  logic [WIDTH_WARM:0]   warm_inc;
  logic                  comb_en_q, comb_en_d;
  logic                  strobe_run_q, strobe_run_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  period_end, start, flushing, running, warm_done, overwrite;

  assign flushing  = (state_q == ST_FLUSH);
  assign running   = (state_q == ST_WARMUP) || (state_q == ST_RUN);
  assign start     = (state_q == ST_IDLE) && enable;
  assign integ_en  = in_valid && running;
  assign integ_clr = flushing;
  assign comb_clr  = flushing;

  assign warm_inc  = {1'b0, warm_q} + WARM_ONE_W;
  assign warm_done = (warm_inc == STAGES_W);

  // Only strobes from periods completed in RUN carry a word the consumer should see.
  assign overwrite = enable && strobe_run_q && out_valid_q && !out_ready;

  cic_decim_counter #(
    .WIDTH (WIDTH_CTR)
  ) u_decim_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (start),
    .load_val   (cfg_ratio),
    .clr        (flushing),
    .inc        (integ_en),
    .period_end (period_end)
  );

  always_comb begin
    state_d      = state_q;
    warm_d       = warm_q;
    comb_en_d    = enable && period_end;
    strobe_run_d = enable && period_end && (state_q == ST_RUN);
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q;

    if (strobe_run_q) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (overwrite) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_FLUSH;
          overrun_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        warm_d  = '0;
        state_d = (STAGES == 0) ? ST_RUN : ST_WARMUP;
      end
      ST_WARMUP: begin
        if (period_end) begin
          warm_d = warm_inc[WIDTH_WARM-1:0];
          if (warm_done) state_d = ST_RUN;
        end
      end
      default: ;
    endcase

    // Dropping enable wins over everything; overrun is deliberately left as is.
    if (!enable) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      warm_q       <= '0;
      comb_en_q    <= 1'b0;
      strobe_run_q <= 1'b0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_q       <= warm_d;
      comb_en_q    <= comb_en_d;
      strobe_run_q <= strobe_run_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign comb_en   = comb_en_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign state     = state_q;

`ifdef CIC_DROP_CNT_EN
  logic [3:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (start) begin
      drop_d = '0;
    end else if (overwrite && (drop_q != 4'hF)) begin
      drop_d = drop_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule
